uart_tx: RTL and testbench

- 8N1 UART transmitter; the return path from the GPU top-level to the host, paired with the existing UART receiver on ui_in[3].
- Accepts bytes through a valid/ready handshake into a small FIFO, then serialises them LSB-first on a registered tx line.
- Generates its own bit timing from clk; intended for status/readback frames (e.g. vertex-shader or raster debug values) sent to an output pin.

---
 rtl/uart_pkg.sv | 6 +
 rtl/uart_tx_fifo.sv | 38 +++
 rtl/uart_tx.sv | 109 ++++++++++
 tb/tb_uart_tx.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART constants and transmitter state encoding.
package uart_pkg;
  localparam int UART_DATA_BITS = 8;
  localparam int UART_CLKS_PER_BIT = 217;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;
endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: synchronous FIFO; push/pop in, rd_data (head), full, empty, count out.
module uart_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic push_ok, pop_ok;
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign push_ok = push && !full;
  assign pop_ok = pop && !empty;
  assign rd_data = mem[rd_ptr];
  always_ff @(posedge clk)
    if (push_ok) mem[wr_ptr] <= wr_data;
  always_ff @(posedge clk)
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= push_ok ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr <= pop_ok ? rd_ptr + 1'b1 : rd_ptr;
      count <= count + CW'(push_ok) - CW'(pop_ok);
    end
endmodule

// File: rtl/uart_tx.sv
// uart_tx: 8N1 transmitter; tx_data/tx_start/tx_ready handshake into a FIFO, registered tx line, tx_busy, tx_done_tick.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [UART_DATA_BITS-1:0] tx_data,
  input  logic                      tx_start,
  output logic                      tx_ready,
  output logic                      tx,
  output logic                      tx_busy,
  output logic                      tx_done_tick
);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(UART_DATA_BITS);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] BIT_LAST = IW'(UART_DATA_BITS - 1);
  tx_state_t state, state_n;
  logic [BW-1:0] baud, baud_n;
  logic [IW-1:0] bit_idx, bit_n;
  logic [UART_DATA_BITS-1:0] shift, shift_n, head;
  logic [CW-1:0] count, count_n;
  logic tx_n, push, pop, full, empty, baud_last;
  assign tx_ready = !full;
  assign push = tx_start && !full;
  assign baud_last = baud == BAUD_LAST;
  assign tx_done_tick = state == STOP && baud_last;
  // occupancy after this edge, so tx_busy can be registered without lagging
  assign count_n = count + CW'(push) - CW'(pop);
  uart_tx_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(UART_DATA_BITS)
  ) fifo (
    .clk(clk),
    .reset(reset),
    .push(push),
    .wr_data(tx_data),
    .pop(pop),
    .rd_data(head),
    .full(full),
    .empty(empty),
    .count(count)
  );
  always_comb begin
    state_n = state;
    baud_n = baud_last ? '0 : baud + 1'b1;
    bit_n = bit_idx;
    shift_n = shift;
    tx_n = tx;
    pop = 1'b0;
    case (state)
      IDLE: begin
        baud_n = '0;
        if (!empty) begin
          pop = 1'b1;
          shift_n = head;
          tx_n = 1'b0;
          state_n = START;
        end
      end
      START: if (baud_last) begin
        tx_n = shift[0];
        bit_n = '0;
        state_n = DATA;
      end
      DATA: if (baud_last) begin
        if (bit_idx == BIT_LAST) begin
          tx_n = 1'b1;
          state_n = STOP;
        end else begin
          shift_n = shift >> 1;
          tx_n = shift[1];
          bit_n = bit_idx + 1'b1;
        end
      end
      STOP: if (baud_last) begin
        // chain straight into the next start bit when more bytes are queued
        if (!empty) begin
          pop = 1'b1;
          shift_n = head;
          tx_n = 1'b0;
          state_n = START;
        end else begin
          state_n = IDLE;
        end
      end
    endcase
  end
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      baud <= '0;
      bit_idx <= '0;
      shift <= '0;
      tx <= 1'b1;
      tx_busy <= 1'b0;
    end else begin
      state <= state_n;
      baud <= baud_n;
      bit_idx <= bit_n;
      shift <= shift_n;
      tx <= tx_n;
      tx_busy <= state_n != IDLE || count_n != '0;
    end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: randomized self-checking bench for uart_tx against a frame-level reference model.
module tb_uart_tx;
  localparam int C = 4;
  localparam int DEPTH = 4;
  localparam int CB = 217;
  localparam int MAXN = 300;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [7:0] tx_data = '0;
  logic tx_start = 1'b0;
  logic tx_ready, tx, tx_busy, tx_done_tick;
  logic [7:0] data_b = '0;
  logic start_b = 1'b0;
  logic ready_b, tx_b, busy_b, done_b;
  int n_checks = 0;
  int n_fail = 0;
  logic stim_v [MAXN+1];
  logic [7:0] stim_d [MAXN+1];
  logic act_tx [MAXN], act_done [MAXN], act_ready [MAXN], act_busy [MAXN];
  logic exp_tx [MAXN], exp_done [MAXN], exp_ready [MAXN], exp_busy [MAXN];
  logic [7:0] rx_q [$];
  logic [7:0] rx_byte;
  int rx_count = 0;
  int done_b_count = 0;

  uart_tx #(.CLKS_PER_BIT(C), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .tx_data(tx_data), .tx_start(tx_start),
    .tx_ready(tx_ready), .tx(tx), .tx_busy(tx_busy), .tx_done_tick(tx_done_tick)
  );
  uart_tx #(.CLKS_PER_BIT(CB), .FIFO_DEPTH(DEPTH)) dut_lb (
    .clk(clk), .reset(reset), .tx_data(data_b), .tx_start(start_b),
    .tx_ready(ready_b), .tx(tx_b), .tx_busy(busy_b), .tx_done_tick(done_b)
  );

  always #5 clk = ~clk;

  // behavioural 8N1 receiver: mid-bit sampling, frame accepted only with a valid stop bit
  always begin
    @(negedge tx_b);
    repeat (CB / 2) @(negedge clk);
    if (tx_b == 1'b0) begin
      for (int k = 0; k < 8; k++) begin
        repeat (CB) @(negedge clk);
        rx_byte[k] = tx_b;
      end
      repeat (CB) @(negedge clk);
      if (tx_b == 1'b1) begin
        rx_q.push_back(rx_byte);
        rx_count++;
      end
    end
  end

  always @(negedge clk) if (done_b === 1'b1) done_b_count++;

  function automatic logic frame_bit(input logic [7:0] b, input int k);
    return k == 0 ? 1'b0 : k == 9 ? 1'b1 : b[k-1];
  endfunction

  task automatic clear_stim;
    for (int i = 0; i <= MAXN; i++) begin
      stim_v[i] = 1'b0;
      stim_d[i] = '0;
    end
  endtask

  task automatic drive(input int i);
    tx_start = stim_v[i];
    tx_data = stim_d[i];
  endtask

  // log index e holds the outputs after stimulus edge e
  task automatic capture(input int n);
    @(negedge clk);
    drive(0);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      act_tx[i] = tx;
      act_done[i] = tx_done_tick;
      act_ready[i] = tx_ready;
      act_busy[i] = tx_busy;
      drive(i + 1);
    end
  endtask

  // reference: a byte queue of DEPTH slots and a line that is busy for 10*C cycles per frame
  task automatic model(input int n);
    logic [7:0] q [$];
    logic [7:0] cur = '0;
    int fs = -1000;
    for (int e = 0; e < n; e++) begin
      automatic bit rdy = q.size() < DEPTH;
      if (e >= fs + 10 * C && q.size() > 0) begin
        cur = q.pop_front();
        fs = e;
      end
      if (stim_v[e] && rdy) q.push_back(stim_d[e]);
      exp_tx[e] = (e < fs + 10 * C) ? frame_bit(cur, (e - fs) / C) : 1'b1;
      exp_done[e] = e == fs + 10 * C - 1;
      exp_busy[e] = (e < fs + 10 * C) || q.size() > 0;
      exp_ready[e] = q.size() < DEPTH;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tx_start = 1'b1;
    tx_data = 8'hAA;
    repeat (3) @(negedge clk);
    n_checks++; if (tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b want 1", tx); end
    n_checks++; if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", tx_ready); end
    n_checks++; if (tx_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", tx_busy); end
    n_checks++; if (tx_done_tick !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", tx_done_tick); end
    tx_start = 1'b0;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (tx_busy !== 1'b0) begin n_fail++; $display("FAIL reset_no_push: busy got %b want 0", tx_busy); end
    n_checks++; if (tx !== 1'b1) begin n_fail++; $display("FAIL reset_idle_tx: got %b want 1", tx); end
  endtask

  task automatic test_single;
    int pulses = 0;
    clear_stim();
    stim_v[0] = 1'b1;
    stim_d[0] = 8'h55;
    model(45);
    capture(45);
    for (int i = 0; i < 45; i++) begin
      pulses += int'(act_done[i] === 1'b1);
      n_checks++; if (act_tx[i] !== exp_tx[i]) begin n_fail++; $display("FAIL single_tx[%0d]: got %b want %b", i, act_tx[i], exp_tx[i]); end
      n_checks++; if (act_done[i] !== exp_done[i]) begin n_fail++; $display("FAIL single_done[%0d]: got %b want %b", i, act_done[i], exp_done[i]); end
      n_checks++; if (act_busy[i] !== exp_busy[i]) begin n_fail++; $display("FAIL single_busy[%0d]: got %b want %b", i, act_busy[i], exp_busy[i]); end
      n_checks++; if (act_ready[i] !== exp_ready[i]) begin n_fail++; $display("FAIL single_ready[%0d]: got %b want %b", i, act_ready[i], exp_ready[i]); end
    end
    n_checks++; if (act_tx[1] !== 1'b0 || act_tx[0] !== 1'b1) begin n_fail++; $display("FAIL single_latency: tx[0..1] got %b%b want 10", act_tx[0], act_tx[1]); end
    n_checks++; if (act_done[40] !== 1'b1 || act_busy[41] !== 1'b0) begin n_fail++; $display("FAIL single_end: done40 %b busy41 %b want 1 0", act_done[40], act_busy[41]); end
    n_checks++; if (pulses != 1) begin n_fail++; $display("FAIL single_pulses: got %0d want 1", pulses); end
  endtask

  task automatic test_back_to_back;
    int pulses = 0;
    clear_stim();
    stim_v[0] = 1'b1; stim_d[0] = 8'hA5;
    stim_v[1] = 1'b1; stim_d[1] = 8'h3C;
    stim_v[2] = 1'b1; stim_d[2] = 8'hFF;
    model(130);
    capture(130);
    for (int i = 0; i < 130; i++) begin
      pulses += int'(act_done[i] === 1'b1);
      n_checks++; if (act_tx[i] !== exp_tx[i]) begin n_fail++; $display("FAIL b2b_tx[%0d]: got %b want %b", i, act_tx[i], exp_tx[i]); end
      n_checks++; if (act_done[i] !== exp_done[i]) begin n_fail++; $display("FAIL b2b_done[%0d]: got %b want %b", i, act_done[i], exp_done[i]); end
      n_checks++; if (act_busy[i] !== exp_busy[i]) begin n_fail++; $display("FAIL b2b_busy[%0d]: got %b want %b", i, act_busy[i], exp_busy[i]); end
    end
    n_checks++; if (pulses != 3) begin n_fail++; $display("FAIL b2b_pulses: got %0d want 3", pulses); end
    n_checks++; if (act_tx[41] !== 1'b0 || act_tx[81] !== 1'b0 || act_done[120] !== 1'b1) begin n_fail++; $display("FAIL b2b_gapless: tx41 %b tx81 %b done120 %b want 0 0 1", act_tx[41], act_tx[81], act_done[120]); end
  endtask

  task automatic test_backpressure;
    int pulses = 0;
    clear_stim();
    for (int i = 0; i < 8; i++) begin
      stim_v[i] = 1'b1;
      stim_d[i] = 8'(i);
    end
    model(210);
    capture(210);
    for (int i = 0; i < 210; i++) begin
      pulses += int'(act_done[i] === 1'b1);
      n_checks++; if (act_tx[i] !== exp_tx[i]) begin n_fail++; $display("FAIL bp_tx[%0d]: got %b want %b", i, act_tx[i], exp_tx[i]); end
      n_checks++; if (act_ready[i] !== exp_ready[i]) begin n_fail++; $display("FAIL bp_ready[%0d]: got %b want %b", i, act_ready[i], exp_ready[i]); end
    end
    n_checks++; if (pulses != 5) begin n_fail++; $display("FAIL bp_frames: got %0d want 5", pulses); end
    n_checks++; if (act_ready[3] !== 1'b1 || act_ready[4] !== 1'b0) begin n_fail++; $display("FAIL bp_fill: ready3 %b ready4 %b want 1 0", act_ready[3], act_ready[4]); end
    n_checks++; if (act_ready[40] !== 1'b0 || act_ready[41] !== 1'b1) begin n_fail++; $display("FAIL bp_release: ready40 %b ready41 %b want 0 1", act_ready[40], act_ready[41]); end
  endtask

  task automatic test_simul_push_pop;
    clear_stim();
    for (int i = 0; i < 45; i++) begin
      stim_v[i] = 1'b1;
      stim_d[i] = 8'($urandom);
    end
    model(250);
    capture(250);
    for (int i = 0; i < 250; i++) begin
      n_checks++; if (act_tx[i] !== exp_tx[i]) begin n_fail++; $display("FAIL simul_tx[%0d]: got %b want %b", i, act_tx[i], exp_tx[i]); end
      n_checks++; if (act_ready[i] !== exp_ready[i]) begin n_fail++; $display("FAIL simul_ready[%0d]: got %b want %b", i, act_ready[i], exp_ready[i]); end
      n_checks++; if (act_busy[i] !== exp_busy[i]) begin n_fail++; $display("FAIL simul_busy[%0d]: got %b want %b", i, act_busy[i], exp_busy[i]); end
    end
    n_checks++; if (act_ready[41] !== 1'b1 || act_ready[42] !== 1'b0) begin n_fail++; $display("FAIL simul_refill: ready41 %b ready42 %b want 1 0", act_ready[41], act_ready[42]); end
    n_checks++; if (act_done[240] !== 1'b1 || act_busy[241] !== 1'b0) begin n_fail++; $display("FAIL simul_six_frames: done240 %b busy241 %b want 1 0", act_done[240], act_busy[241]); end
  endtask

  task automatic test_random;
    for (int r = 0; r < 3; r++) begin
      clear_stim();
      for (int i = 0; i < 30; i++) begin
        stim_v[i] = 1'($urandom_range(1));
        stim_d[i] = 8'($urandom);
      end
      model(250);
      capture(250);
      for (int i = 0; i < 250; i++) begin
        n_checks++; if (act_tx[i] !== exp_tx[i]) begin n_fail++; $display("FAIL rand%0d_tx[%0d]: got %b want %b", r, i, act_tx[i], exp_tx[i]); end
        n_checks++; if (act_done[i] !== exp_done[i]) begin n_fail++; $display("FAIL rand%0d_done[%0d]: got %b want %b", r, i, act_done[i], exp_done[i]); end
        n_checks++; if (act_ready[i] !== exp_ready[i]) begin n_fail++; $display("FAIL rand%0d_ready[%0d]: got %b want %b", r, i, act_ready[i], exp_ready[i]); end
        n_checks++; if (act_busy[i] !== exp_busy[i]) begin n_fail++; $display("FAIL rand%0d_busy[%0d]: got %b want %b", r, i, act_busy[i], exp_busy[i]); end
      end
    end
  endtask

  task automatic test_reset_mid(input logic [7:0] b, input int bitpos);
    int n = 1 + C * (1 + bitpos) + 2;
    int bad = 0;
    clear_stim();
    for (int i = 0; i < 3; i++) begin
      stim_v[i] = 1'b1;
      stim_d[i] = i == 0 ? b : 8'($urandom);
    end
    capture(n);
    n_checks++; if (act_tx[n-1] !== b[bitpos]) begin n_fail++; $display("FAIL rmid_bit%0d: got %b want %b", bitpos, act_tx[n-1], b[bitpos]); end
    reset = 1'b1;
    @(negedge clk);
    n_checks++; if (tx !== 1'b1) begin n_fail++; $display("FAIL rmid_tx: got %b want 1", tx); end
    n_checks++; if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_ready: got %b want 1", tx_ready); end
    n_checks++; if (tx_busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy: got %b want 0", tx_busy); end
    n_checks++; if (tx_done_tick !== 1'b0) begin n_fail++; $display("FAIL rmid_done: got %b want 0", tx_done_tick); end
    reset = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      bad += int'(tx !== 1'b1 || tx_busy !== 1'b0 || tx_done_tick !== 1'b0);
    end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL rmid_quiet: %0d active cycles after reset, want 0", bad); end
  endtask

  task automatic test_loopback;
    logic [7:0] sent [$];
    int waited;
    for (int i = 0; i < 16; i++) begin
      sent.push_back(8'($urandom));
      waited = 0;
      while (ready_b !== 1'b1 && waited < 5000) begin
        @(negedge clk);
        waited++;
      end
      start_b = 1'b1;
      data_b = sent[i];
      @(negedge clk);
      start_b = 1'b0;
    end
    waited = 0;
    while ((rx_count < 16 || busy_b !== 1'b0) && waited < 16 * 10 * CB + 3000) begin
      @(negedge clk);
      waited++;
    end
    repeat (2 * CB) @(negedge clk);
    n_checks++; if (rx_count != 16) begin n_fail++; $display("FAIL lb_count: got %0d want 16", rx_count); end
    n_checks++; if (done_b_count != 16) begin n_fail++; $display("FAIL lb_done_ticks: got %0d want 16", done_b_count); end
    n_checks++; if (busy_b !== 1'b0) begin n_fail++; $display("FAIL lb_busy: got %b want 0", busy_b); end
    for (int i = 0; i < 16; i++) begin
      n_checks++;
      if (i >= rx_q.size() || rx_q[i] !== sent[i]) begin
        n_fail++;
        $display("FAIL lb_byte[%0d]: got %h want %h", i, i < rx_q.size() ? rx_q[i] : 8'hxx, sent[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_simul_push_pop();
    test_random();
    test_reset_mid(8'h0F, 3);
    test_reset_mid(8'hF0, 3);
    test_loopback();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
